inst_queue: RTL
===============

# inst_queue

Parametrised dual-issue instruction queue between instruction fetch and decode. Accepts up to two fetched words per cycle and presents the two oldest words to decode, which pops zero, one or two per cycle. It replaces the wait-register scheme with an all-or-nothing write handshake, a live occupancy count and a sticky error flag. Flush discards all contents in one cycle.

## Interface
- `DATA_W`, 64, width of one queue entry (instruction word plus side bits)
- `DEPTH`, 8, number of entries; power of two, ≥ 4
- `CNT_W`, $clog2(DEPTH)+1, width of the occupancy count (derived; do not override)
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-low reset
- `flush`  in  1  discard all entries this cycle (pipeline redirect)
- `w_ena_1`  in  1  write request, slot 1 (older)
- `w_ena_2`  in  1  write request, slot 2 (younger)
- `w_data_1`  in  DATA_W  slot 1 data
- `w_data_2`  in  DATA_W  slot 2 data
- `fifo_stall_req`  out  1  requested writes do not fit this cycle; nothing is written
- `p_data_1`  in  1  pop oldest entry
- `p_data_2`  in  1  pop second-oldest entry (only together with `p_data_1`)
- `r_data_1`  out  DATA_W  oldest entry; 0 when `r_data_1_ok`=0
- `r_data_2`  out  DATA_W  second-oldest entry; 0 when `r_data_2_ok`=0
- `r_data_1_ok`  out  1  count ≥ 1
- `r_data_2_ok`  out  1  count ≥ 2
- `count`  out  CNT_W  current number of valid entries, 0..DEPTH
- `err`  out  1  sticky protocol error (illegal pop request)

## Operation
- Storage: DEPTH×DATA_W array; `w_ptr`, `r_ptr` of CNT_W bits; index = low $clog2(DEPTH) bits; wrap is modulo 2·DEPTH on the pointer and modulo DEPTH on the index.
- `count` = `w_ptr` − `r_ptr` (CNT_W-bit modular); full when count = DEPTH.
- Write request size `nw` = `w_ena_1` + `w_ena_2`. `w_ena_2` alone is legal and writes `w_data_2` as a single entry; with both set, `w_data_1` goes to `w_ptr` and `w_data_2` to `w_ptr`+1.
- `fifo_stall_req` = (DEPTH − count) < `nw`, computed from current count only; same-cycle pops do not create room. When asserted, no entry is written and `w_ptr` holds; upstream re-presents the same data. No internal holding registers.
- Pop size `np`: `p_data_1`&`p_data_2` → 2; `p_data_1` only → 1; none → 0. Pop is clamped to available entries: min(`np`, count). `p_data_2` without `p_data_1` pops nothing and sets `err`.
- Push and pop in the same cycle are both applied; `count` next = count + accepted writes − actual pops.
- `flush` (rst high): pointers → 0, count → 0; any write or pop in that cycle is discarded; `err` is not cleared.
- Reset (`rst`=0): pointers → 0, `err` → 0; storage array contents are not reset.
- Priority: reset > flush > push/pop.

## Timing
- Reset values: `count`=0, `r_data_1_ok`=0, `r_data_2_ok`=0, `r_data_1`=0, `r_data_2`=0, `err`=0; `fifo_stall_req`=0 unless `w_ena` is asserted with `nw` > DEPTH − 0 (impossible), so 0.
- `fifo_stall_req`, `r_data_*`, `r_data_*_ok` are combinational from registered state and same-cycle `w_ena_*`; no input-to-output path from `p_data_*`.
- Write latency: data accepted at edge N is visible on `r_data_1`/`r_data_2` in cycle N+1.
- Pop takes effect at the edge; next entries appear in the following cycle.
- Full with simultaneous pop of 2 and write of 2: stall asserted, write dropped, pop applied; count DEPTH → DEPTH−2.
- One free slot with `nw`=2: stall, nothing written (no partial write).
- Empty with pop requested: no pointer change, `err` not set (clamped pop is legal).
- Pointer wrap past 2·DEPTH−1 continues seamlessly; ordering preserved across index wrap.

## Test plan
- Reset, then write pairs (A0,A1),(A2,A3) in two cycles, no pops → count=4, `r_data_1`=A0, `r_data_2`=A1, both ok=1.
- Fill DEPTH=8 with pairs, then `w_ena_1`=1 only → `fifo_stall_req`=1, count stays 8; pop 2 next cycle → count=6, stall drops, retry accepted → count=7.
- count=7, both writes plus double pop same cycle → stall=1, count=5, no entry from the write appears.
- count=1, `p_data_1`&`p_data_2` → one entry popped, count=0, `r_data_1_ok`=0, `r_data_1`=0, `err`=0; then `p_data_2` alone → `err`=1, stays 1 through flush, cleared by `rst`=0.
- Stream 40 single writes of incrementing values with concurrent single pops → popped sequence equals written sequence across several pointer wraps, count never exceeds 2.
- count=5 with `flush`=1 and both writes active → next cycle count=0, ok flags 0; the flushed-cycle write data never appears.

Source files
------------

// File: rtl/inst_queue_if.sv
// Fetch/decode-facing signal bundle for the dual-issue instruction queue.
// The master modport is the fetch+decode side; the slave modport is the queue itself.
interface inst_queue_if #(
    parameter  int DATA_W = 64,
    parameter  int DEPTH  = 8,
    localparam int CNT_W  = $clog2(DEPTH) + 1
);
    // Writes are all-or-nothing: when fifo_stall_req is high in a cycle with
    // w_ena_* set, nothing is written and fetch re-presents the same words.
    // Pops are unconditional requests, clamped by the queue to its occupancy.
    logic              w_ena_1;
    logic              w_ena_2;
    logic [DATA_W-1:0] w_data_1;
    logic [DATA_W-1:0] w_data_2;
    logic              fifo_stall_req;
    logic              p_data_1;
    logic              p_data_2;
    logic [DATA_W-1:0] r_data_1;
    logic [DATA_W-1:0] r_data_2;
    logic              r_data_1_ok;
    logic              r_data_2_ok;
    logic [CNT_W-1:0]  count;
    logic              err;

    modport master (
        output w_ena_1, w_ena_2, w_data_1, w_data_2, p_data_1, p_data_2,
        input  fifo_stall_req, r_data_1, r_data_2, r_data_1_ok, r_data_2_ok,
               count, err
    );

    modport slave (
        input  w_ena_1, w_ena_2, w_data_1, w_data_2, p_data_1, p_data_2,
        output fifo_stall_req, r_data_1, r_data_2, r_data_1_ok, r_data_2_ok,
               count, err
    );
endinterface

// File: rtl/inst_queue.sv
// Dual-issue instruction queue: up to two writes and two pops per cycle,
// all-or-nothing write stall, live occupancy count and sticky pop-error flag.
module inst_queue #(
    parameter  int DATA_W = 64,
    parameter  int DEPTH  = 8,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    inst_queue_if.slave  q
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  w_ptr, r_ptr;
    logic [CNT_W-1:0]  cnt, free, nw, np_req, np;
    logic [IDX_W-1:0]  w_idx, w_idx_n, r_idx, r_idx_n;
    logic              stall, pop_err, err_q;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        cnt     = w_ptr - r_ptr;
        free    = CNT_W'(DEPTH) - cnt;
        nw      = CNT_W'(q.w_ena_1) + CNT_W'(q.w_ena_2);
        stall   = free < nw;
        pop_err = q.p_data_2 & ~q.p_data_1;
        np_req  = '0;
        if (q.p_data_1 && q.p_data_2) begin
            np_req = CNT_W'(2);
        end else if (q.p_data_1) begin
            np_req = CNT_W'(1);
        end
        np = (np_req < cnt) ? np_req : cnt;
    end

    assign w_idx   = w_ptr[IDX_W-1:0];
    assign w_idx_n = w_idx + IDX_W'(1);
    assign r_idx   = r_ptr[IDX_W-1:0];
    assign r_idx_n = r_idx + IDX_W'(1);

    // A lone w_ena_2 lands in the slot w_data_1 would have taken.
    always_ff @(posedge clk) begin
        if (rst && !flush && !stall) begin
            if (q.w_ena_1) begin
                mem[w_idx] <= q.w_data_1;
            end
            if (q.w_ena_2) begin
                mem[q.w_ena_1 ? w_idx_n : w_idx] <= q.w_data_2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            w_ptr <= '0;
            r_ptr <= '0;
            err_q <= 1'b0;
        end else if (flush) begin
            w_ptr <= '0;
            r_ptr <= '0;
        end else begin
            if (!stall) begin
                w_ptr <= w_ptr + nw;
            end
            r_ptr <= r_ptr + np;
            if (pop_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign q.fifo_stall_req = stall;
    assign q.count          = cnt;
    assign q.r_data_1_ok    = (cnt != '0);
    assign q.r_data_2_ok    = (cnt >= CNT_W'(2));
    assign q.r_data_1       = q.r_data_1_ok ? mem[r_idx]   : '0;
    assign q.r_data_2       = q.r_data_2_ok ? mem[r_idx_n] : '0;
    assign q.err            = err_q;
endmodule
